dmem_portb_arbiter: RTL and testbench

- Shares the data-RAM secondary port (byte address, 4-bit byte write-enable, 32-bit write data, 32-bit synchronous read data, 1-cycle read latency) between two requesters: requester 0 (debug module) and requester 1 (DMA / memory-loader engine).
- Round-robin arbitration with bounded bursts, valid/ready request handshake and per-requester response strobes.
- Sits between the requesters and the data RAM's port B; the CPU pipeline's port A is untouched.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/rr_burst_grant.sv | 71 +++++++
 rtl/dmem_portb_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_portb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-RAM port-B arbiter.
//   DMEM_DEPTH_WORDS : default data-RAM size in 32-bit words
//   WE_READ          : byte write-enable value that denotes a read
//   dmem_req_t       : one requester's access (write-enable, byte address, write data)
//   req_id_t         : requester identity (debug module = REQ0, DMA engine = REQ1)
package dmem_pkg;

    localparam int         DMEM_DEPTH_WORDS = 4096;
    localparam logic [3:0] WE_READ          = 4'b0000;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_burst_grant.sv
// Two-input round-robin grant with bounded bursts.
// The current owner keeps the port while the other side waits only until it
// has taken MAX_BURST consecutive grants; an idle cycle breaks the burst.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset (no grant while high)
//   valid  in   [1:0] request present, bit i = requester i
//   grant  out  [1:0] one-hot grant (all zero when nothing is granted)
module rr_burst_grant
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    req_id_t          last_gnt_reg, last_gnt_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    req_id_t          winner;
    logic             keep_owner;

    always_comb begin
        grant          = 2'b00;
        winner         = last_gnt_reg;
        last_gnt_next  = last_gnt_reg;
        burst_cnt_next = burst_cnt_reg;
        // A zero count means the burst was broken (or never started), so a
        // tie goes to the side that did not win last.
        keep_owner     = (burst_cnt_reg != '0) && (burst_cnt_reg < CNT_MAX);

        if (!rst) begin
            case (valid)
                2'b01:   winner = REQ0;
                2'b10:   winner = REQ1;
                2'b11:   winner = keep_owner ? last_gnt_reg
                                             : ((last_gnt_reg == REQ0) ? REQ1 : REQ0);
                default: winner = last_gnt_reg;
            endcase
            if (valid != 2'b00) begin
                grant = (winner == REQ1) ? 2'b10 : 2'b01;
            end
        end

        if (grant == 2'b00) begin
            burst_cnt_next = '0;
        end else if (winner == last_gnt_reg) begin
            burst_cnt_next = (burst_cnt_reg == CNT_MAX) ? CNT_MAX : burst_cnt_reg + CNT_ONE;
        end else begin
            last_gnt_next  = winner;
            burst_cnt_next = CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg  <= REQ1;
            burst_cnt_reg <= '0;
        end else begin
            last_gnt_reg  <= last_gnt_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

endmodule

// File: rtl/dmem_portb_arbiter.sv
// Shares the data-RAM secondary port between the debug module (r0) and the
// DMA / memory-loader engine (r1). One access per cycle, combinational drive
// of the RAM in the accept cycle, response strobe exactly one cycle later.
// Optional feature macro: DMEM_ARB_BOUNDS_EN -- accesses with addr[31:2] >=
// DEPTH_WORDS are accepted but never write, and answer with resp_err = 1.
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   rX_req_valid/ready            request handshake (ready = grant this cycle)
//   rX_req_we/addr/wdata          byte write-enable (0000 = read), byte address, data
//   rX_resp_valid                 response strobe for the request accepted last cycle
//   resp_rdata, resp_err          shared response data / out-of-range flag
//   mem_we/addr/wdata, mem_rdata  RAM port B (read data one cycle after address)
module dmem_portb_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_BURST   = 4,
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req_valid,
    output logic        r0_req_ready,
    input  logic [3:0]  r0_req_we,
    input  logic [31:0] r0_req_addr,
    input  logic [31:0] r0_req_wdata,
    input  logic        r1_req_valid,
    output logic        r1_req_ready,
    input  logic [3:0]  r1_req_we,
    input  logic [31:0] r1_req_addr,
    input  logic [31:0] r1_req_wdata,
    output logic        r0_resp_valid,
    output logic        r1_resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS_ON = 1'b1;
`else
    localparam bit BOUNDS_ON = 1'b0;
`endif
    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH_WORDS);

    dmem_req_t  r0_req, r1_req, sel_req;
    logic [1:0] grant;
    logic       accept;
    logic       oob;
    logic       resp_live;

    logic       resp_v_reg;
    req_id_t    resp_id_reg;
    logic       rd_reg;
    logic       err_reg;

    assign r0_req = '{we: r0_req_we, addr: r0_req_addr, wdata: r0_req_wdata};
    assign r1_req = '{we: r1_req_we, addr: r1_req_addr, wdata: r1_req_wdata};

    rr_burst_grant #(
        .MAX_BURST (MAX_BURST)
    ) u_grant (
        .clk   (clk),
        .rst   (rst),
        .valid ({r1_req_valid, r0_req_valid}),
        .grant (grant)
    );

    assign r0_req_ready = grant[0];
    assign r1_req_ready = grant[1];
    assign accept       = |grant;

    always_comb begin
        sel_req = '0;
        if (grant[1]) begin
            sel_req = r1_req;
        end else if (grant[0]) begin
            sel_req = r0_req;
        end
    end

    // sel_req is all-zero without a grant, so oob can only be set on an accept.
    assign oob = BOUNDS_ON && (sel_req.addr[31:2] >= WORD_LIMIT);

    assign mem_we    = oob ? WE_READ : sel_req.we;
    assign mem_addr  = sel_req.addr;
    assign mem_wdata = sel_req.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_v_reg  <= 1'b0;
            resp_id_reg <= REQ0;
            rd_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            resp_v_reg  <= accept;
            resp_id_reg <= grant[1] ? REQ1 : REQ0;
            rd_reg      <= (sel_req.we == WE_READ);
            err_reg     <= oob;
        end
    end

    // A response registered just before reset rises is dropped, not delivered
    // during the reset cycle.
    assign resp_live     = resp_v_reg && !rst;
    assign r0_resp_valid = resp_live && (resp_id_reg == REQ0);
    assign r1_resp_valid = resp_live && (resp_id_reg == REQ1);
    assign resp_rdata    = (resp_live && rd_reg && !err_reg) ? mem_rdata : 32'h0;

`ifdef DMEM_ARB_BOUNDS_EN
    assign resp_err = resp_live && err_reg;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
module tb_dmem_portb_arbiter;

    localparam int MAXB  = 4;
    localparam int DEPTH = 4096;
`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [3:0]  we0 = 4'h0, we1 = 4'h0;
    logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wd0 = 32'h0, wd1 = 32'h0;
    logic        r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_portb_arbiter #(
        .MAX_BURST   (MAXB),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .r0_req_valid  (v0),
        .r0_req_ready  (r0_req_ready),
        .r0_req_we     (we0),
        .r0_req_addr   (addr0),
        .r0_req_wdata  (wd0),
        .r1_req_valid  (v1),
        .r1_req_ready  (r1_req_ready),
        .r1_req_we     (we1),
        .r1_req_addr   (addr1),
        .r1_req_wdata  (wd1),
        .r0_resp_valid (r0_resp_valid),
        .r1_resp_valid (r1_resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // RAM stub standing in for port B: byte writes, registered read.
    logic [31:0] ram    [0:8191];
    logic [31:0] shadow [0:8191];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) ram[mem_addr[14:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= ram[mem_addr[14:2]];
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            ram[i]    = {16'hC0DE, 16'(i)};
            shadow[i] = {16'hC0DE, 16'(i)};
        end
        ram[5]    = 32'hDEADBEEF;
        shadow[5] = 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Grant history since reset: 0/1 = requester granted, -1 = idle cycle.
    int          hist[$];
    bit          pend_v    = 1'b0;
    int          pend_id   = 0;
    logic [31:0] pend_data = 32'h0;
    bit          pend_err  = 1'b0;

    // Tie rule from the grant history: the side that won most recently keeps
    // the port while its current unbroken run is shorter than MAXB.
    function automatic int tie_winner();
        int last = 1;
        int run  = 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] >= 0) begin
                last = hist[k];
                break;
            end
        end
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k] != last) break;
            run++;
        end
        return (run > 0 && run < MAXB) ? last : 1 - last;
    endfunction

    always @(negedge clk) begin : model_cmp
        int          eg;
        logic [3:0]  ewe, orig_we;
        logic [31:0] ea, ew;
        bit          eoob, live;
        eg = -1;
        if (!rst) begin
            if (v0 && v1)  eg = tie_winner();
            else if (v0)   eg = 0;
            else if (v1)   eg = 1;
        end
        ewe = 4'h0; ea = 32'h0; ew = 32'h0;
        if (eg == 0) begin ewe = we0; ea = addr0; ew = wd0; end
        if (eg == 1) begin ewe = we1; ea = addr1; ew = wd1; end
        orig_we = ewe;
        eoob = BOUNDS && (eg >= 0) && (int'(ea[31:2]) >= DEPTH);
        if (eoob) ewe = 4'h0;

        chk("r0_ready",  32'(r0_req_ready), 32'(eg == 0));
        chk("r1_ready",  32'(r1_req_ready), 32'(eg == 1));
        chk("mem_we",    32'(mem_we), 32'(ewe));
        chk("mem_addr",  mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);

        live = pend_v && !rst;
        chk("r0_resp_valid", 32'(r0_resp_valid), 32'(live && pend_id == 0));
        chk("r1_resp_valid", 32'(r1_resp_valid), 32'(live && pend_id == 1));
        if (live) begin
            chk("resp_rdata", resp_rdata, pend_data);
            chk("resp_err",   32'(resp_err), 32'(pend_err));
            $display("resp r%0d rdata=%08h err=%0d t=%0t", pend_id, resp_rdata, resp_err, $time);
        end

        if (rst) begin
            hist.delete();
            pend_v = 1'b0;
        end else begin
            hist.push_back(eg);
            pend_v    = (eg >= 0);
            pend_id   = eg;
            pend_err  = eoob;
            pend_data = (orig_we == 4'h0 && !eoob) ? shadow[ea[14:2]] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (ewe[b]) shadow[ea[14:2]][8*b +: 8] = ew[8*b +: 8];
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int seq[9];
    int exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        // Reset state
        step(); step();
        #1;
        chk("rst_r0_ready", 32'(r0_req_ready), 32'h0);
        chk("rst_rdata",    resp_rdata, 32'h0);
        chk("rst_err",      32'(resp_err), 32'h0);
        step();
        rst = 1'b0;
        step();

        // 1: single read of word 5
        v0 = 1'b1; we0 = 4'h0; addr0 = 32'h14;
        #1;
        chk("t1_ready", 32'(r0_req_ready), 32'h1);
        step();
        v0 = 1'b0;
        #1;
        chk("t1_resp_valid", 32'(r0_resp_valid), 32'h1);
        chk("t1_rdata",      resp_rdata, 32'hDEADBEEF);
        chk("t1_r1_silent",  32'(r1_resp_valid), 32'h0);
        step();

        // 2: r1 half-word write then read back
        v1 = 1'b1; we1 = 4'b0011; addr1 = 32'h20; wd1 = 32'h0000ABCD;
        #1;
        chk("t2_wr_ready", 32'(r1_req_ready), 32'h1);
        step();
        we1 = 4'h0; wd1 = 32'h0;
        #1;
        chk("t2_wr_resp",  32'(r1_resp_valid), 32'h1);
        chk("t2_wr_rdata", resp_rdata, 32'h0);
        step();
        v1 = 1'b0;
        #1;
        chk("t2_rd_rdata", resp_rdata, 32'hC0DEABCD);
        step();

        // 3: continuous contention from reset
        rst = 1'b1; step(); rst = 1'b0;
        v0 = 1'b1; v1 = 1'b1; we0 = 4'h0; we1 = 4'h0; addr0 = 32'h100; addr1 = 32'h200;
        for (int i = 0; i < 9; i++) begin
            #1;
            seq[i] = r1_req_ready ? 1 : (r0_req_ready ? 0 : -1);
            step();
            if (seq[i] == 0) addr0 = addr0 + 32'h4;
            if (seq[i] == 1) addr1 = addr1 + 32'h4;
        end
        for (int i = 0; i < 9; i++) chk($sformatf("t3_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        v0 = 1'b0; v1 = 1'b0;
        step();

        // 4: burst broken by an idle cycle
        rst = 1'b1; step(); rst = 1'b0;
        v0 = 1'b1; addr0 = 32'h30;
        step(); step(); step();
        v0 = 1'b0;
        step();
        v0 = 1'b1; v1 = 1'b1; addr1 = 32'h34;
        #1;
        chk("t4_r1_wins", 32'(r1_req_ready), 32'h1);
        chk("t4_r0_wait", 32'(r0_req_ready), 32'h0);
        step();
        v0 = 1'b0; v1 = 1'b0;
        step();

        // 5: reset in the middle of a contended stream
        rst = 1'b1; step(); rst = 1'b0;
        v0 = 1'b1; we0 = 4'hF; addr0 = 32'hA0; wd0 = 32'h13572468;
        v1 = 1'b1; we1 = 4'h0; addr1 = 32'h40;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("t5_r0_ready", 32'(r0_req_ready), 32'h0);
        chk("t5_r1_ready", 32'(r1_req_ready), 32'h0);
        chk("t5_mem_we",   32'(mem_we), 32'h0);
        chk("t5_resp_drop", 32'(r0_resp_valid), 32'h0);
        chk("t5_ram_written", ram[40], 32'h13572468);
        step();
        rst = 1'b0;
        #1;
        chk("t5_first_tie_r0", 32'(r0_req_ready), 32'h1);
        step();
        v0 = 1'b0; v1 = 1'b0; we0 = 4'h0;
        step();

        // Mixed traffic: requesters hold their request until accepted.
        for (int i = 0; i < 60; i++) begin
            logic g0, g1;
            #1;
            g0 = r0_req_ready; g1 = r1_req_ready;
            step();
            if (g0 || !v0) begin
                v0 = ($urandom % 4) != 0;
                we0 = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
                addr0 = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                wd0 = $urandom;
            end
            if (g1 || !v1) begin
                v1 = ($urandom % 4) != 0;
                we1 = (($urandom % 3) == 0) ? 4'($urandom) : 4'h0;
                addr1 = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                wd1 = $urandom;
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        step(); step();

`ifdef DMEM_ARB_BOUNDS_EN
        // 6: out-of-range write is accepted, suppressed and flagged
        v1 = 1'b1; we1 = 4'hF; addr1 = 32'h0000_4000; wd1 = 32'h55AA55AA;
        #1;
        chk("t6_ready",  32'(r1_req_ready), 32'h1);
        chk("t6_mem_we", 32'(mem_we), 32'h0);
        step();
        v1 = 1'b0; we1 = 4'h0;
        #1;
        chk("t6_resp_valid", 32'(r1_resp_valid), 32'h1);
        chk("t6_resp_err",   32'(resp_err), 32'h1);
        chk("t6_rdata",      resp_rdata, 32'h0);
        chk("t6_ram_kept",   ram[4096], 32'hC0DE1000);
        step();
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
